uivtc: RTL
==========

// Module: uivtc
// PURPOSE
//  Video timing controller: free-running raster counters that generate VS/HS/DE and active-pixel
//  coordinates for one video clock domain. Sits directly upstream of the test pattern generator
//  and display encoder, driving their vs/hs/de inputs. Start/stop is gated to frame boundaries so
//  downstream never sees a truncated frame. Default timing is 1280x720@60 (74.25 MHz pixel clock).
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch, clocks
//  H_SYNC    40    hsync width, clocks
//  H_BP      220   horizontal back porch, clocks
//  V_ACTIVE  720   active lines per frame
//  V_FP      5     vertical front porch, lines
//  V_SYNC    5     vsync width, lines
//  V_BP      20    vertical back porch, lines
//  HS_POL    1'b1  hsync active level
//  VS_POL    1'b1  vsync active level
// PORTS
//  I_vtc_clk   in   1   pixel clock
//  I_vtc_rst   in   1   reset: asynchronous, active-high
//  I_vtc_en    in   1   run request; level-sensitive, sampled every cycle
//  O_vtc_vs    out  1   vertical sync, polarity VS_POL
//  O_vtc_hs    out  1   horizontal sync, polarity HS_POL
//  O_vtc_de    out  1   active-video enable
//  O_vtc_x     out  12  active pixel column 0..H_ACTIVE-1; 0 when de=0
//  O_vtc_y     out  12  active line 0..V_ACTIVE-1; 0 when de=0
//  O_vtc_fs    out  1   one-cycle frame-start pulse (h=0,v=0)
//  O_vtc_busy  out  1   1 in RUN or DRAIN
// BEHAVIOUR
//  - H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP, V_TOTAL likewise; both must be <=4096 (12-bit counters).
//  - h_cnt 0..H_TOTAL-1 wraps to 0; v_cnt increments when h_cnt wraps; v_cnt wraps at V_TOTAL-1.
//  - Line order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, +H_ACTIVE), front porch.
//    Frame order is identical in lines; vs transitions only at h_cnt==0.
//  - de = h_active && v_active; x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP).
//  - All outputs registered: decoded from counters, valid one clock after the counter value.
//    vs/hs/de/x/y/fs are mutually aligned.
//  - Reset (async): FSM=IDLE, counters=0, vs=~VS_POL, hs=~HS_POL, de=0, x=y=0, fs=0, busy=0.
//    Reset mid-frame clears outputs immediately, with no drain.
//  - FSM states:
//    IDLE : counters held at 0, outputs inactive. en=1 -> RUN; first RUN cycle has h=v=0.
//    RUN  : counters advance. en=0 -> DRAIN. en=1 at frame end (h=H_TOTAL-1, v=V_TOTAL-1) -> wrap,
//           stay RUN.
//    DRAIN: counters advance. en=1 -> RUN (no glitch, frame continues).
//           Frame end with en=0 -> IDLE, counters 0.
//  - Simultaneous: en=0 on the frame-end cycle in RUN -> IDLE directly (frame complete).
//  - fs asserts on the first output cycle of every frame, including the first after IDLE.
//  - en toggling faster than a frame never produces a partial frame or a counter jump.
// STRUCTURE
//  - Shared include uivtc_defs.vh: timing presets (640x480@60, 720p60, 1080p60) as localparams
//    and FSM state encodings (2-bit).
//  - One sub-module: uivtc_axis. Generic wrap counter plus region decoder (sync/active flags and
//    active offset), params SYNC/BP/ACTIVE/FP. Instantiated twice: H (inc every clock when
//    advancing) and V (inc on H wrap).
//  - Top level holds the FSM and output registers.
// TESTING (sim params: H 8/2/2/2 -> H_TOTAL=14; V 4/1/1/1 -> V_TOTAL=7)
//  - Reset release, en=0 for 50 clocks -> vs=hs=0, de=0, busy=0, fs never pulses.
//  - en=1 held -> fs at first output cycle; hs high 2 clocks every 14; de high 8 clocks/line on
//    lines 2..5; x runs 0..7; y runs 0..3; frame period 98 clocks.
//  - Drop en at mid-frame (v=3) -> frame completes to 98 clocks, then idle, busy=0; no extra fs.
//  - Drop en for 10 clocks mid-frame and reraise -> no interruption; next fs exactly 98 clocks
//    after the previous one.
//  - Assert reset at h=10, v=3 -> outputs inactive within the same cycle. On release with en=1,
//    the frame restarts from h=v=0.
//  - HS_POL=0, VS_POL=0 -> idle levels are 1; sync pulses low; de/x/y timing unchanged.

Source files
------------

// File: rtl/uivtc_pkg.sv
// Shared types and constants for the uivtc video timing controller:
// FSM encoding, counter width and standard raster timing presets.
package uivtc_pkg;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } vtc_state_t;

  // 640x480@60 (25.175 MHz)
  localparam int P480_H_ACTIVE  = 640;
  localparam int P480_H_FP      = 16;
  localparam int P480_H_SYNC    = 96;
  localparam int P480_H_BP      = 48;
  localparam int P480_V_ACTIVE  = 480;
  localparam int P480_V_FP      = 10;
  localparam int P480_V_SYNC    = 2;
  localparam int P480_V_BP      = 33;

  // 1280x720@60 (74.25 MHz)
  localparam int P720_H_ACTIVE  = 1280;
  localparam int P720_H_FP      = 110;
  localparam int P720_H_SYNC    = 40;
  localparam int P720_H_BP      = 220;
  localparam int P720_V_ACTIVE  = 720;
  localparam int P720_V_FP      = 5;
  localparam int P720_V_SYNC    = 5;
  localparam int P720_V_BP      = 20;

  // 1920x1080@60 (148.5 MHz)
  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

endpackage

// File: rtl/uivtc_if.sv
// Timing bundle between the VTC (master) and its downstream consumers
// such as the pattern generator and display encoder (slave).
interface uivtc_if;
  import uivtc_pkg::*;

  logic             I_vtc_en;
  logic             O_vtc_vs;
  logic             O_vtc_hs;
  logic             O_vtc_de;
  logic [CNT_W-1:0] O_vtc_x;
  logic [CNT_W-1:0] O_vtc_y;
  logic             O_vtc_fs;
  logic             O_vtc_busy;

  modport master (
    input  I_vtc_en,
    output O_vtc_vs, O_vtc_hs, O_vtc_de, O_vtc_x, O_vtc_y, O_vtc_fs, O_vtc_busy
  );

  modport slave (
    output I_vtc_en,
    input  O_vtc_vs, O_vtc_hs, O_vtc_de, O_vtc_x, O_vtc_y, O_vtc_fs, O_vtc_busy
  );

endinterface

// File: rtl/uivtc_axis.sv
// One raster axis: wrap counter with sync/back-porch/active/front-porch
// region decode. Used once for pixels within a line and once for lines.
module uivtc_axis
  import uivtc_pkg::*;
#(
  parameter int SYNC   = 40,
  parameter int BP     = 220,
  parameter int ACTIVE = 1280,
  parameter int FP     = 110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_p0,
  output logic [CNT_W-1:0] offset,
  output logic             last,
  output logic             in_sync,
  output logic             in_active
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC - 1);
  localparam logic [CNT_W-1:0] ACT_FIRST = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(SYNC + BP + ACTIVE - 1);

  generate
    if (TOTAL > CNT_MAX || SYNC < 1 || ACTIVE < 1) begin : g_bad_timing
      $error("uivtc_axis: timing does not fit a %0d-bit counter", CNT_W);
    end
  endgenerate

  assign last = (cnt_p0 == CNT_LAST);

  // Counter stage: held at zero whenever the controller is not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (!run) begin
      cnt_p0 <= '0;
    end else if (inc) begin
      cnt_p0 <= last ? '0 : cnt_p0 + 1'b1;
    end
  end

  always_comb begin
    in_sync   = (cnt_p0 <= SYNC_LAST);
    in_active = (cnt_p0 >= ACT_FIRST) && (cnt_p0 <= ACT_LAST);
    offset    = in_active ? (cnt_p0 - ACT_FIRST) : '0;
  end

endmodule

// File: rtl/uivtc.sv
// Video timing controller: free-running raster counters producing
// registered VS/HS/DE, active coordinates and a frame-start pulse.
module uivtc
  import uivtc_pkg::*;
#(
  parameter int   H_ACTIVE = P720_H_ACTIVE,
  parameter int   H_FP     = P720_H_FP,
  parameter int   H_SYNC   = P720_H_SYNC,
  parameter int   H_BP     = P720_H_BP,
  parameter int   V_ACTIVE = P720_V_ACTIVE,
  parameter int   V_FP     = P720_V_FP,
  parameter int   V_SYNC   = P720_V_SYNC,
  parameter int   V_BP     = P720_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input logic      I_vtc_clk,
  input logic      I_vtc_rst,
  uivtc_if.master  vtc
);

  vtc_state_t       state_p0;
  vtc_state_t       state_nxt;
  logic             vld_p0;
  logic             frame_end;

  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;
  logic [CNT_W-1:0] h_off;
  logic [CNT_W-1:0] v_off;
  logic             h_last;
  logic             v_last;
  logic             h_sync;
  logic             v_sync;
  logic             h_act;
  logic             v_act;
  logic             de_now;

  logic             vs_p1;
  logic             hs_p1;
  logic             de_p1;
  logic [CNT_W-1:0] x_p1;
  logic [CNT_W-1:0] y_p1;
  logic             fs_p1;
  logic             busy_p1;

  assign vld_p0    = (state_p0 != ST_IDLE);
  assign frame_end = h_last && v_last;

  uivtc_axis #(
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP)
  ) u_h_axis (
    .clk       (I_vtc_clk),
    .rst       (I_vtc_rst),
    .run       (vld_p0),
    .inc       (1'b1),
    .cnt_p0    (h_cnt_p0),
    .offset    (h_off),
    .last      (h_last),
    .in_sync   (h_sync),
    .in_active (h_act)
  );

  uivtc_axis #(
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP)
  ) u_v_axis (
    .clk       (I_vtc_clk),
    .rst       (I_vtc_rst),
    .run       (vld_p0),
    .inc       (h_last),
    .cnt_p0    (v_cnt_p0),
    .offset    (v_off),
    .last      (v_last),
    .in_sync   (v_sync),
    .in_active (v_act)
  );

  always_ff @(posedge I_vtc_clk or posedge I_vtc_rst) begin
    if (I_vtc_rst) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Stopping is only honoured at frame end, so a dropped enable drains
  // the frame in progress and a re-raised one simply continues it.
  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      ST_IDLE: begin
        if (vtc.I_vtc_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!vtc.I_vtc_en) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vtc.I_vtc_en)   state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign de_now = h_act && v_act;

  // Output stage: decode of the counter values one clock earlier
  always_ff @(posedge I_vtc_clk or posedge I_vtc_rst) begin
    if (I_vtc_rst) begin
      vs_p1   <= ~VS_POL;
      hs_p1   <= ~HS_POL;
      de_p1   <= 1'b0;
      x_p1    <= '0;
      y_p1    <= '0;
      fs_p1   <= 1'b0;
      busy_p1 <= 1'b0;
    end else begin
      busy_p1 <= (state_nxt != ST_IDLE);
      if (vld_p0) begin
        vs_p1 <= v_sync ? VS_POL : ~VS_POL;
        hs_p1 <= h_sync ? HS_POL : ~HS_POL;
        de_p1 <= de_now;
        x_p1  <= de_now ? h_off : '0;
        y_p1  <= de_now ? v_off : '0;
        fs_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      end else begin
        vs_p1 <= ~VS_POL;
        hs_p1 <= ~HS_POL;
        de_p1 <= 1'b0;
        x_p1  <= '0;
        y_p1  <= '0;
        fs_p1 <= 1'b0;
      end
    end
  end

  assign vtc.O_vtc_vs   = vs_p1;
  assign vtc.O_vtc_hs   = hs_p1;
  assign vtc.O_vtc_de   = de_p1;
  assign vtc.O_vtc_x    = x_p1;
  assign vtc.O_vtc_y    = y_p1;
  assign vtc.O_vtc_fs   = fs_p1;
  assign vtc.O_vtc_busy = busy_p1;

endmodule
